stall_ctrl: RTL and testbench

Central pipeline stall/flush controller for the 5-stage core. Collects stall requests from IF, ID (load-use hazard), EX (multi-cycle MDU ops) and MEM. Drives the 6-bit `stall` vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) plus a global `flush`. Each register treats `stall[k]==Stop && stall[k+1]==NoStop` as "insert bubble".

---
 rtl/stall_ctrl_pkg.sv | 21 ++
 rtl/stall_mdu_timer.sv | 66 ++++++
 rtl/stall_ctrl.sv | 92 +++++++++
 tb/tb_stall_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the stall controller: stall vector
// encodings and MDU timer state encodings.
package stall_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // stall[0]=PC ... stall[5]=WB, 1 = Stop
   localparam logic [5:0] StallMem  = 6'b011111;
   localparam logic [5:0] StallEx   = 6'b001111;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallIf   = 6'b000011;
   localparam logic [5:0] StallNone = 6'b000000;

   localparam logic [1:0] MduIdle = 2'd0;
   localparam logic [1:0] MduBusy = 2'd1;
   localparam logic [1:0] MduDone = 2'd2;

endpackage

// File: rtl/stall_mdu_timer.sv
// MDU latency timer: holds EX for L-1 cycles, then reports done.
// Ports: clk, reset, start, lat[5:0], ex_adv, flush -> busy, done.
module stall_mdu_timer
   import stall_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] lat,
   input  logic       ex_adv,
   input  logic       flush,
   output logic       busy,
   output logic       done
);

   logic [1:0] state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MduIdle: begin
            if (start) begin
               if (lat <= 6'd1) begin
                  done = 1'b1;
               end else begin
                  busy    = 1'b1;
                  cnt_d   = lat - 6'd1;
                  // L=2 stalls only in the start cycle
                  state_d = (lat == 6'd2) ? MduDone : MduBusy;
               end
            end
         end
         MduBusy: begin
            busy  = 1'b1;
            cnt_d = cnt_q - 6'd1;
            // next cycle is the L-th one
            if (cnt_q == 6'd2) state_d = MduDone;
         end
         MduDone: begin
            done = 1'b1;
            if (ex_adv) state_d = MduIdle;
         end
         default: state_d = MduIdle;
      endcase
      if (flush) begin
         state_d = MduIdle;
         cnt_d   = 6'd0;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MduIdle;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/stall_ctrl.sv
// Central stall/flush controller with priority flush>MEM>EX>ID>IF.
// Ports: hazard/request inputs -> stall[5:0], flush, mdu_done, perf_*.
// Optional per-cause stall counters: define STALL_PERF_EN.
module stall_ctrl
   import stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_if,
   input  logic        req_mem,
   input  logic        ex_mem_to_regfile,
   input  logic [4:0]  ex_rn,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_mdu_start,
   input  logic [5:0]  ex_mdu_lat,
   input  logic        exc_flush,
   output logic [5:0]  stall,
   output logic        flush,
   output logic        mdu_done,
   output logic [31:0] perf_if,
   output logic [31:0] perf_id,
   output logic [31:0] perf_ex,
   output logic [31:0] perf_mem
);

   logic load_use;
   logic mdu_busy;

   assign load_use = ex_mem_to_regfile && (ex_rn != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_rn)) ||
                      (id_use_rt && (id_rt == ex_rn)));

   always_comb begin
      flush = 1'b0;
      stall = StallNone;
      if (exc_flush)     flush = 1'b1;
      else if (req_mem)  stall = StallMem;
      else if (mdu_busy) stall = StallEx;
      else if (load_use) stall = StallId;
      else if (req_if)   stall = StallIf;
   end

   stall_mdu_timer u_mdu (
      .clk    (clk),
      .reset  (reset),
      .start  (ex_mdu_start),
      .lat    (ex_mdu_lat),
      .ex_adv (stall[3] == NoStop),
      .flush  (exc_flush),
      .busy   (mdu_busy),
      .done   (mdu_done)
   );

`ifdef STALL_PERF_EN
   logic [31:0] pif_q, pid_q, pex_q, pmem_q;
   logic        sel_if, sel_id, sel_ex, sel_mem;

   // stall encodings are unique per cause, so match on them
   assign sel_mem = !flush && (stall == StallMem);
   assign sel_ex  = !flush && (stall == StallEx);
   assign sel_id  = !flush && (stall == StallId);
   assign sel_if  = !flush && (stall == StallIf);

   always_ff @(posedge clk) begin
      if (reset) begin
         pif_q  <= ZeroWord;
         pid_q  <= ZeroWord;
         pex_q  <= ZeroWord;
         pmem_q <= ZeroWord;
      end else begin
         if (sel_if  && pif_q  != '1) pif_q  <= pif_q  + 32'd1;
         if (sel_id  && pid_q  != '1) pid_q  <= pid_q  + 32'd1;
         if (sel_ex  && pex_q  != '1) pex_q  <= pex_q  + 32'd1;
         if (sel_mem && pmem_q != '1) pmem_q <= pmem_q + 32'd1;
      end
   end

   assign perf_if  = pif_q;
   assign perf_id  = pid_q;
   assign perf_ex  = pex_q;
   assign perf_mem = pmem_q;
`else
   assign perf_if  = ZeroWord;
   assign perf_id  = ZeroWord;
   assign perf_ex  = ZeroWord;
   assign perf_mem = ZeroWord;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl.
// Uses immediate assertions; one summary line at the end.
module tb_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_if, req_mem, ex_mem_to_regfile;
   logic [4:0]  ex_rn, id_rs, id_rt;
   logic        id_use_rs, id_use_rt;
   logic        ex_mdu_start;
   logic [5:0]  ex_mdu_lat;
   logic        exc_flush;
   logic [5:0]  stall;
   logic        flush, mdu_done;
   logic [31:0] perf_if, perf_id, perf_ex, perf_mem;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stall_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .req_if            (req_if),
      .req_mem           (req_mem),
      .ex_mem_to_regfile (ex_mem_to_regfile),
      .ex_rn             (ex_rn),
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_use_rs         (id_use_rs),
      .id_use_rt         (id_use_rt),
      .ex_mdu_start      (ex_mdu_start),
      .ex_mdu_lat        (ex_mdu_lat),
      .exc_flush         (exc_flush),
      .stall             (stall),
      .flush             (flush),
      .mdu_done          (mdu_done),
      .perf_if           (perf_if),
      .perf_id           (perf_id),
      .perf_ex           (perf_ex),
      .perf_mem          (perf_mem)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // stall, flush, mdu_done in one call
   task automatic chk3(input string tag, input logic [5:0] s,
                       input logic f, input logic d);
      chk({tag, ".stall"}, {26'd0, stall}, {26'd0, s});
      chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
      chk({tag, ".done"}, {31'd0, mdu_done}, {31'd0, d});
   endtask

   // advance one cycle; inputs change 1 unit after the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_if = 1'b0; req_mem = 1'b1;
      ex_mem_to_regfile = 1'b0; ex_rn = 5'd0;
      id_rs = 5'd0; id_rt = 5'd0;
      id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_mdu_start = 1'b0; ex_mdu_lat = 6'd0; exc_flush = 1'b0;

      // reset held 2 cycles with req_mem
      #2;
      chk3("rst_mem0", 6'b011111, 1'b0, 1'b0);
      tick;
      chk3("rst_mem1", 6'b011111, 1'b0, 1'b0);
      tick;
      reset = 1'b0; req_mem = 1'b0;
      #1;
      chk3("post_rst", 6'b000000, 1'b0, 1'b0);
      chk("perf_if0", perf_if, 32'd0);
      chk("perf_id0", perf_id, 32'd0);
      chk("perf_ex0", perf_ex, 32'd0);
      chk("perf_mem0", perf_mem, 32'd0);

      // load-use on rs
      ex_mem_to_regfile = 1'b1; ex_rn = 5'd5;
      id_rs = 5'd5; id_use_rs = 1'b1;
      #1; chk3("lu_rs", 6'b000111, 1'b0, 1'b0);
      req_if = 1'b1;
      #1; chk3("lu_if", 6'b000111, 1'b0, 1'b0);
      ex_rn = 5'd0; id_rs = 5'd0;
      #1; chk3("lu_r0_if", 6'b000011, 1'b0, 1'b0);
      req_if = 1'b0;
      #1; chk3("lu_r0", 6'b000000, 1'b0, 1'b0);
      // load-use on rt
      ex_rn = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
      id_use_rs = 1'b1; id_use_rt = 1'b1;
      #1; chk3("lu_rt", 6'b000111, 1'b0, 1'b0);
      id_use_rt = 1'b0;
      #1; chk3("lu_rt_unused", 6'b000000, 1'b0, 1'b0);
      ex_mem_to_regfile = 1'b0; id_use_rs = 1'b0;
      tick;

      // MDU L=4
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd4;
      #1; chk3("l4_c1", 6'b001111, 1'b0, 1'b0);
      tick; ex_mdu_start = 1'b0;
      #1; chk3("l4_c2", 6'b001111, 1'b0, 1'b0);
      tick; chk3("l4_c3", 6'b001111, 1'b0, 1'b0);
      tick; chk3("l4_c4", 6'b000000, 1'b0, 1'b1);
      tick; chk3("l4_idle", 6'b000000, 1'b0, 1'b0);

      // MDU L=1
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd1;
      #1; chk3("l1_c1", 6'b000000, 1'b0, 1'b1);
      tick; ex_mdu_start = 1'b0;
      #1; chk3("l1_c2", 6'b000000, 1'b0, 1'b0);

      // MDU L=2: one stall cycle then done
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd2;
      #1; chk3("l2_c1", 6'b001111, 1'b0, 1'b0);
      tick; ex_mdu_start = 1'b0;
      #1; chk3("l2_c2", 6'b000000, 1'b0, 1'b1);
      tick; chk3("l2_idle", 6'b000000, 1'b0, 1'b0);

      // L=4 with req_mem in cycles 3..5
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd4;
      #1; chk3("lm_c1", 6'b001111, 1'b0, 1'b0);
      tick; ex_mdu_start = 1'b0;
      #1; chk3("lm_c2", 6'b001111, 1'b0, 1'b0);
      tick; req_mem = 1'b1;
      #1; chk3("lm_c3", 6'b011111, 1'b0, 1'b0);
      tick; chk3("lm_c4", 6'b011111, 1'b0, 1'b1);
      tick; chk3("lm_c5", 6'b011111, 1'b0, 1'b1);
      tick; req_mem = 1'b0;
      #1; chk3("lm_c6", 6'b000000, 1'b0, 1'b1);
      tick; chk3("lm_c7", 6'b000000, 1'b0, 1'b0);

      // flush in BUSY cycle 2 of L=10
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd10;
      #1; chk3("fl_c1", 6'b001111, 1'b0, 1'b0);
      tick; ex_mdu_start = 1'b0; exc_flush = 1'b1; req_mem = 1'b1;
      #1; chk3("fl_c2", 6'b000000, 1'b1, 1'b0);
      tick; exc_flush = 1'b0; req_mem = 1'b0;
      #1; chk3("fl_c3", 6'b000000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk3("fl_after", 6'b000000, 1'b0, 1'b0);
      end

      // reset mid-BUSY, reset beats flush
      ex_mdu_start = 1'b1; ex_mdu_lat = 6'd8;
      #1; chk3("rb_c1", 6'b001111, 1'b0, 1'b0);
      tick; ex_mdu_start = 1'b0;
      #1; chk3("rb_c2", 6'b001111, 1'b0, 1'b0);
      reset = 1'b1; exc_flush = 1'b1;
      tick; reset = 1'b0; exc_flush = 1'b0;
      #1; chk3("rb_c3", 6'b000000, 1'b0, 1'b0);
      tick; chk3("rb_c4", 6'b000000, 1'b0, 1'b0);

      // perf: clear, then 7 IF cycles with 2 MEM overlapping
      reset = 1'b1;
      tick; reset = 1'b0;
      req_if = 1'b1;
      tick; tick;
      req_mem = 1'b1;
      #1; chk3("pf_mem", 6'b011111, 1'b0, 1'b0);
      tick; tick;
      req_mem = 1'b0;
      tick; tick; tick;
      req_if = 1'b0;
      #1;
`ifdef STALL_PERF_EN
      chk("perf_if", perf_if, 32'd5);
      chk("perf_mem", perf_mem, 32'd2);
`else
      chk("perf_if", perf_if, 32'd0);
      chk("perf_mem", perf_mem, 32'd0);
`endif
      chk("perf_id", perf_id, 32'd0);
      chk("perf_ex", perf_ex, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
